// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC / instruction-fetch stage.
// Holds the datapath width, the sequential increment, the reset vector and the FSM encoding.
package pc_fetch_unit_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned ILEN_DEFAULT = 4;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Next-PC selection: jump target, PC-relative branch or sequential increment.
// Also flags a selected target that is not word aligned.
module pc_fetch_unit_next_pc_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned ILEN = ILEN_DEFAULT
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_br_offset,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic            i_br_taken,
  input  logic            i_jump,
  output logic [XLEN-1:0] o_next_pc_c,
  output logic            o_misaligned_c
);

  logic [XLEN-1:0] w_next_pc;

  // Jump has priority over a taken branch; additions wrap modulo 2^XLEN.
  always_comb begin
    w_next_pc = i_pc + XLEN'(ILEN);
    if (i_jump) begin
      w_next_pc = i_jump_target;
    end else if (i_br_taken) begin
      w_next_pc = i_pc + i_br_offset;
    end
  end

  assign o_next_pc_c    = w_next_pc;
  assign o_misaligned_c = |w_next_pc[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: fetch handshake, instruction latch,
// next-PC update on retire and a sticky halt on misaligned targets.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned     ILEN         = ILEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic [XLEN-1:0] o_imem_addr,
  output logic            o_imem_req,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_instr,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_pc,
  input  logic            i_stall,
  input  logic            i_retire,
  input  logic            i_br_taken,
  input  logic [XLEN-1:0] i_br_offset,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_jump_target,
  output logic            o_misalign
);

  state_e          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_req;
  logic            r_valid;
  logic            r_misalign;

  logic [XLEN-1:0] w_next_pc;
  logic            w_next_misaligned;

  pc_fetch_unit_next_pc_sel #(
    .ILEN (ILEN)
  ) u_next_pc_sel (
    .i_pc           (r_pc),
    .i_br_offset    (i_br_offset),
    .i_jump_target  (i_jump_target),
    .i_br_taken     (i_br_taken),
    .i_jump         (i_jump),
    .o_next_pc_c    (w_next_pc),
    .o_misaligned_c (w_next_misaligned)
  );

  // Request and valid are registered alongside the state so each tracks its state exactly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VECTOR;
      r_instr    <= '0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
        end
        ST_FETCH: begin
          if (i_imem_ack) begin
            r_instr <= i_imem_rdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (i_retire && !i_stall) begin
            r_valid <= 1'b0;
            if (w_next_misaligned) begin
              r_misalign <= 1'b1;
              r_state    <= ST_HALT;
            end else begin
              r_pc    <= w_next_pc;
              r_req   <= 1'b1;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
        default: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_state <= ST_HALT;
        end
      endcase
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_imem_req    = r_req;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_valid;
  assign o_misalign    = r_misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized
// instruction streams compared against a simple architectural PC model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        stall;
  logic        retire;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        jump;
  logic [31:0] jump_target;
  logic        misalign;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .RESET_VECTOR (RV),
    .ILEN         (4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_addr   (imem_addr),
    .o_imem_req    (imem_req),
    .i_imem_ack    (imem_ack),
    .i_imem_rdata  (imem_rdata),
    .o_instr       (instr),
    .o_instr_valid (instr_valid),
    .o_pc          (pc),
    .i_stall       (stall),
    .i_retire      (retire),
    .i_br_taken    (br_taken),
    .i_br_offset   (br_offset),
    .i_jump        (jump),
    .i_jump_target (jump_target),
    .o_misalign    (misalign)
  );

  // Architectural rule for the next PC, written straight from the ISA description.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic b,
                                             input logic [31:0] off, input logic j,
                                             input logic [31:0] tgt);
    if (j) return tgt;
    if (b) return cur + off;
    return cur + 32'd4;
  endfunction

  task automatic clear_inputs();
    imem_ack    = 1'b0;
    imem_rdata  = $urandom;
    stall       = 1'b0;
    retire      = 1'b0;
    br_taken    = 1'b0;
    br_offset   = $urandom;
    jump        = 1'b0;
    jump_target = $urandom;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc  = RV;
  endtask

  // Wait (bounded) for a request, then answer it after delay cycles.
  task automatic do_fetch(input logic [31:0] data, input int unsigned delay);
    int unsigned cyc = 0;
    while (imem_req !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (imem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL fetch_req_timeout: req=%b required 1", imem_req);
    end
    n_checks++;
    if (imem_addr !== m_pc) begin
      n_errors++;
      $display("FAIL fetch_addr: addr=%h required %h", imem_addr, m_pc);
    end
    repeat (delay) begin @(posedge clk); #1; end
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    n_checks++;
    if (instr !== data || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL fetch_latch: instr=%h valid=%b req=%b required instr=%h valid=1 req=0",
               instr, instr_valid, imem_req, data);
    end
  endtask

  // Retire the current instruction and check the resulting PC / halt state.
  task automatic do_retire(input logic b, input logic [31:0] off, input logic j,
                           input logic [31:0] tgt);
    logic [31:0] exp_next;
    logic        exp_halt;
    exp_next    = model_next(m_pc, b, off, j, tgt);
    exp_halt    = (exp_next[1:0] != 2'b00);
    retire      = 1'b1;
    br_taken    = b;
    br_offset   = off;
    jump        = j;
    jump_target = tgt;
    @(posedge clk); #1;
    clear_inputs();
    if (!exp_halt) m_pc = exp_next;
    n_checks++;
    if (pc !== m_pc || misalign !== exp_halt || imem_req !== !exp_halt || instr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL retire: pc=%h mis=%b req=%b valid=%b required pc=%h mis=%b req=%b valid=0",
               pc, misalign, imem_req, instr_valid, m_pc, exp_halt, !exp_halt);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (pc !== RV || instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0 || misalign !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: pc=%h instr=%h valid=%b req=%b mis=%b required %h/0/0/0/0",
               pc, instr, instr_valid, imem_req, misalign, RV);
    end
    apply_reset();
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL boot_no_req: req=%b required 0", imem_req);
    end
    @(posedge clk); #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RV) begin
      n_errors++;
      $display("FAIL boot_to_fetch: req=%b addr=%h required 1/%h", imem_req, imem_addr, RV);
    end
  endtask

  task automatic test_basic_fetch();
    do_fetch(32'h0000_0013, 0);
    do_retire(1'b0, 32'h0, 1'b0, 32'h0);
    n_checks++;
    if (imem_addr !== 32'h4) begin
      n_errors++;
      $display("FAIL basic_next_addr: addr=%h required 00000004", imem_addr);
    end
  endtask

  task automatic test_branch();
    do_fetch(32'h1111_0001, 1);
    do_retire(1'b0, 32'h0, 1'b1, 32'h100);
    do_fetch(32'h1111_0002, 0);
    do_retire(1'b1, 32'hFFFF_FFF0, 1'b0, 32'h0);
    n_checks++;
    if (pc !== 32'h0F0) begin
      n_errors++;
      $display("FAIL branch_back: pc=%h required 000000f0", pc);
    end
    do_fetch(32'h1111_0003, 0);
    do_retire(1'b0, 32'h0, 1'b1, 32'h100);
    do_fetch(32'h1111_0004, 2);
    do_retire(1'b0, 32'hFFFF_FFF0, 1'b0, 32'h0);
    n_checks++;
    if (pc !== 32'h104) begin
      n_errors++;
      $display("FAIL branch_not_taken: pc=%h required 00000104", pc);
    end
  endtask

  task automatic test_jump_priority();
    do_fetch(32'h2222_0001, 0);
    do_retire(1'b0, 32'h0, 1'b1, 32'h40);
    do_fetch(32'h2222_0002, 0);
    do_retire(1'b1, 32'h8, 1'b1, 32'h200);
    n_checks++;
    if (pc !== 32'h200) begin
      n_errors++;
      $display("FAIL jump_priority: pc=%h required 00000200", pc);
    end
  endtask

  task automatic test_wrap();
    do_fetch(32'h3333_0001, 0);
    do_retire(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    do_fetch(32'h3333_0002, 0);
    do_retire(1'b0, 32'h0, 1'b0, 32'h0);
    n_checks++;
    if (pc !== 32'h0) begin
      n_errors++;
      $display("FAIL wrap_up: pc=%h required 00000000", pc);
    end
    do_fetch(32'h3333_0003, 0);
    do_retire(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    n_checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      n_errors++;
      $display("FAIL wrap_down: pc=%h required fffffffc", pc);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc0;
    do_fetch(32'h4444_0001, 0);
    pc0      = m_pc;
    stall    = 1'b1;
    retire   = 1'b1;
    br_taken = 1'b1;
    br_offset = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (pc !== pc0 || instr !== 32'h4444_0001 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hold: cyc=%0d pc=%h instr=%h valid=%b req=%b required %h/44440001/1/0",
                 i, pc, instr, instr_valid, imem_req, pc0);
      end
    end
    stall = 1'b0;
    @(posedge clk); #1;
    clear_inputs();
    m_pc = pc0 + 32'h10;
    n_checks++;
    if (pc !== m_pc || imem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_release: pc=%h req=%b required %h/1", pc, imem_req, m_pc);
    end
    retire = 1'b1;
    br_taken = 1'b1;
    br_offset = 32'h10;
    @(posedge clk); #1;
    clear_inputs();
    n_checks++;
    if (pc !== m_pc) begin
      n_errors++;
      $display("FAIL stall_single_advance: pc=%h required %h", pc, m_pc);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] pc0;
    do_fetch(32'h5555_0001, 0);
    pc0 = m_pc;
    do_retire(1'b1, 32'h0000_0002, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1;
      retire   = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign !== 1'b1 || pc !== pc0) begin
        n_errors++;
        $display("FAIL halt_sticky: cyc=%0d req=%b valid=%b mis=%b pc=%h required 0/0/1/%h",
                 i, imem_req, instr_valid, misalign, pc, pc0);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_fetch();
    do_fetch(32'h6666_0001, 0);
    do_retire(1'b0, 32'h0, 1'b1, 32'h80);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || pc !== RV) begin
      n_errors++;
      $display("FAIL async_reset: req=%b pc=%h required 0/%h", imem_req, pc, RV);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_pc  = RV;
    do_fetch(32'h6666_0002, 0);
    do_retire(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [12:0] off13;
      logic [31:0] off, tgt;
      int unsigned kind;
      bit          bad;
      kind  = $urandom_range(0, 2);
      bad   = ($urandom_range(0, 11) == 0);
      off13 = 13'($urandom) & 13'h1FFC;
      off   = {{19{off13[12]}}, off13};
      tgt   = $urandom & 32'hFFFF_FFFC;
      if (bad) begin
        off = off | 32'h2;
        tgt = tgt | 32'h2;
      end
      do_fetch($urandom, $urandom_range(0, 3));
      do_retire(kind == 1, off, kind == 2, tgt);
      if (misalign === 1'b1) apply_reset();
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_stall();
    test_misalign();
    apply_reset();
    test_reset_mid_fetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
